// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioner: channel
// priority indices, default debounce sizing and the pulse arbiter grant.
package button_conditioner_pkg;

  localparam int NUM_BTN = 3;

  // Pulse priority: higher index wins arbitration.
  localparam int LEFT   = 2;
  localparam int RIGHT  = 1;
  localparam int CENTER = 0;

  // 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 19;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // WARM0/WARM1 let the synchronizer fill with real samples after reset;
  // ARMING waits for a stable release before any press may be reported.
  typedef enum logic [1:0] {
    CH_WARM0,
    CH_WARM1,
    CH_ARMING,
    CH_ACTIVE
  } ch_state_t;

  function automatic btn_vec_t priority_grant(input btn_vec_t req);
    btn_vec_t grant;
    grant = '0;
    if (req[LEFT])        grant[LEFT]   = 1'b1;
    else if (req[RIGHT])  grant[RIGHT]  = 1'b1;
    else if (req[CENTER]) grant[CENTER] = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: polarity fix, 2-flop synchronizer, stability counter,
// debounced level and a press strobe valid on the edge the level rises.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw_pressed;
  logic             sync_q1;
  logic             sync_q2;
  logic             d_q;
  logic [CNT_W-1:0] cnt_q;
  ch_state_t        state_q;

  assign raw_pressed = ACTIVE_LOW ? ~raw : raw;

  // NOTE: non-blocking assignments make the two flops sample pre-edge values,
  // giving a genuine two-stage chain instead of one collapsed flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_pressed;
      sync_q2 <= sync_q1;
    end
  end

  // Strobe is combinational so the arbiter's pending bit sets on the same
  // edge that d_q rises.
  assign press = (state_q == CH_ACTIVE) && sync_q2 && !d_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_WARM0;
      cnt_q   <= '0;
      d_q     <= 1'b0;
    end else begin
      case (state_q)
        CH_WARM0: state_q <= CH_WARM1;
        CH_WARM1: state_q <= CH_ARMING;
        CH_ARMING: begin
          // A button held through reset must be released stably first.
          if (sync_q2) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= CH_ACTIVE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CH_ACTIVE: begin
          if (sync_q2 == d_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            d_q   <= sync_q2;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= CH_WARM0;
      endcase
    end
  end

  assign lvl = d_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces three raw push-buttons and serializes their press events into
// one-cycle, mutually exclusive pulses (left > right > center).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_center_raw,
  output logic left,
  output logic right,
  output logic center,
  output logic left_lvl,
  output logic right_lvl,
  output logic center_lvl
);

  btn_vec_t raw_vec;
  btn_vec_t press_vec;
  btn_vec_t lvl_vec;
  btn_vec_t pending_q;
  btn_vec_t grant;

  assign raw_vec[LEFT]   = btn_left_raw;
  assign raw_vec[RIGHT]  = btn_right_raw;
  assign raw_vec[CENTER] = btn_center_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[i]),
      .lvl  (lvl_vec[i]),
      .press(press_vec[i])
    );
  end

  assign grant = priority_grant(pending_q);

  // NOTE: reset clears pending, so a press in flight when reset hits is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      left      <= 1'b0;
      right     <= 1'b0;
      center    <= 1'b0;
    end else begin
      // OR after the clear: a new press on the bit being granted survives.
      pending_q <= (pending_q & ~grant) | press_vec;
      left      <= grant[LEFT];
      right     <= grant[RIGHT];
      center    <= grant[CENTER];
    end
  end

  assign left_lvl   = lvl_vec[LEFT];
  assign right_lvl  = lvl_vec[RIGHT];
  assign center_lvl = lvl_vec[CENTER];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with a short debounce window:
// expected pulses are queued at stimulus time and matched by a pulse monitor.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int DB = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_left_raw   = 1'b1;
  logic btn_right_raw  = 1'b1;
  logic btn_center_raw = 1'b1;
  logic left, right, center;
  logic left_lvl, right_lvl, center_lvl;

  int tests_run = 0;
  int failures  = 0;
  int cyc       = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [2:0] mon_obs;
  logic [2:0] mon_exp;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_left_raw  (btn_left_raw),
    .btn_right_raw (btn_right_raw),
    .btn_center_raw(btn_center_raw),
    .left          (left),
    .right         (right),
    .center        (center),
    .left_lvl      (left_lvl),
    .right_lvl     (right_lvl),
    .center_lvl    (center_lvl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse seen is matched against the head of the scoreboard.
  always @(negedge clk) begin
    mon_obs = {left, right, center};
    if (!rst && mon_obs != 3'b000) begin
      tests_run++;
      if ($countones(mon_obs) != 1) begin
        failures++;
        $display("FAIL onehot: pulses=%b at cycle %0d, required exactly one high", mon_obs, cyc);
      end
      tests_run++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: pulses=%b at cycle %0d, required none", mon_obs, cyc);
      end else begin
        mon_e   = sb.pop_front();
        mon_exp = 3'b001 << mon_e.ch;
        if (mon_obs !== mon_exp || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL pulse_match: got pulses=%b at cycle %0d, required %b at cycle %0d",
                   mon_obs, cyc, mon_exp, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missed: %0d pulses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    btn_left_raw = 1'b1; btn_right_raw = 1'b1; btn_center_raw = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({left, right, center, left_lvl, right_lvl, center_lvl} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {left, right, center, left_lvl, right_lvl, center_lvl});
    end
    btn_left_raw = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    tests_run++;
    if (left_lvl !== 1'b0) begin
      failures++;
      $display("FAIL held_through_reset_lvl: got %b, required 0", left_lvl);
    end
    check_drained("held_through_reset");
    btn_left_raw = 1'b1;
    repeat (10) step();
    btn_left_raw = 1'b0;
    c = cyc;
    sb.push_back('{ch: LEFT, cyc: c + 7});
    repeat (12) step();
    tests_run++;
    if (left_lvl !== 1'b1) begin
      failures++;
      $display("FAIL repress_lvl: got %b, required 1", left_lvl);
    end
    check_drained("repress_after_reset");
    btn_left_raw = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_clean_press();
    int c;
    btn_right_raw = 1'b0;
    c = cyc;
    sb.push_back('{ch: RIGHT, cyc: c + 7});
    wait_cyc(c + 5);
    tests_run++;
    if (right_lvl !== 1'b0) begin
      failures++;
      $display("FAIL press_lvl_early: got %b at edge 4, required 0", right_lvl);
    end
    wait_cyc(c + 6);
    tests_run++;
    if (right_lvl !== 1'b1) begin
      failures++;
      $display("FAIL press_lvl: got %b at edge 5, required 1", right_lvl);
    end
    repeat (20) step();
    check_drained("clean_press");
  endtask

  task automatic test_release();
    int c;
    btn_right_raw = 1'b1;
    c = cyc;
    wait_cyc(c + 5);
    tests_run++;
    if (right_lvl !== 1'b1) begin
      failures++;
      $display("FAIL release_lvl_early: got %b at edge 4, required 1", right_lvl);
    end
    wait_cyc(c + 6);
    tests_run++;
    if (right_lvl !== 1'b0) begin
      failures++;
      $display("FAIL release_lvl: got %b at edge 5, required 0", right_lvl);
    end
    repeat (10) step();
    check_drained("release");
  endtask

  task automatic test_bounce();
    int c;
    for (int i = 0; i < 4; i++) begin
      btn_center_raw = i[0];
      step();
    end
    btn_center_raw = 1'b0;
    c = cyc;
    sb.push_back('{ch: CENTER, cyc: c + 7});
    repeat (12) step();
    check_drained("bounce");
    btn_center_raw = 1'b1;
    repeat (10) step();
    tests_run++;
    if (center_lvl !== 1'b0) begin
      failures++;
      $display("FAIL bounce_release_lvl: got %b, required 0", center_lvl);
    end
  endtask

  task automatic test_simultaneous();
    int c;
    btn_left_raw = 1'b0; btn_right_raw = 1'b0; btn_center_raw = 1'b0;
    c = cyc;
    sb.push_back('{ch: LEFT,   cyc: c + 7});
    sb.push_back('{ch: RIGHT,  cyc: c + 8});
    sb.push_back('{ch: CENTER, cyc: c + 9});
    repeat (14) step();
    check_drained("simultaneous");
    tests_run++;
    if ({left_lvl, right_lvl, center_lvl} !== 3'b111) begin
      failures++;
      $display("FAIL simultaneous_lvl: got %b, required 111", {left_lvl, right_lvl, center_lvl});
    end
    btn_left_raw = 1'b1; btn_right_raw = 1'b1; btn_center_raw = 1'b1;
    repeat (10) step();
    tests_run++;
    if ({left_lvl, right_lvl, center_lvl} !== 3'b000) begin
      failures++;
      $display("FAIL simultaneous_release_lvl: got %b, required 000", {left_lvl, right_lvl, center_lvl});
    end
    check_drained("simultaneous_release");
  endtask

  task automatic test_reset_mid_debounce();
    int c;
    btn_left_raw = 1'b0;
    c = cyc;
    while (cyc < c + 3) step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({left, right, center, left_lvl} !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b, required 0000", {left, right, center, left_lvl});
    end
    step();
    rst = 1'b0;
    repeat (20) step();
    tests_run++;
    if (left_lvl !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_held_lvl: got %b, required 0", left_lvl);
    end
    check_drained("mid_reset_held");
    btn_left_raw = 1'b1;
    repeat (10) step();
    btn_left_raw = 1'b0;
    c = cyc;
    sb.push_back('{ch: LEFT, cyc: c + 7});
    repeat (12) step();
    check_drained("mid_reset_repress");
    btn_left_raw = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly upstream of the controller-state conversion logic: turns raw board push-buttons (left, right, center) into clean, debounced, one-cycle press pulses.
- The FSM then sees exactly one direction/select event per physical press, never a multi-cycle level or contact bounce.
- Also provides debounced level outputs for any consumer that needs "button held".

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- CNT_W, 19, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_left_raw  in  1  raw left button, asynchronous to clk.
- btn_right_raw  in  1  raw right button, asynchronous.
- btn_center_raw  in  1  raw center button, asynchronous.
- left  out  1  one-cycle press pulse.
- right  out  1  one-cycle press pulse.
- center  out  1  one-cycle press pulse.
- left_lvl, right_lvl, center_lvl  out  1 each  debounced pressed level, active-high.

Behaviour:
- Reset: all outputs 0; synchronizers and debounced levels hold the "released" value; counters 0; pending bits 0. Reset mid-press drops any in-flight event. A button still held when reset is released must be seen as released and then stable before its first pulse, i.e. no pulse until the button is released and pressed again.
- Per channel, when ACTIVE_LOW=1:
  - Invert the raw input, then pass it through a 2-flop synchronizer to give s.
- Debounce, per channel, with debounced level d:
  - If s == d, the counter clears to 0.
  - If s != d and counter == DEBOUNCE_CYCLES-1, d <= s and the counter clears.
  - Otherwise the counter increments.
  - Any bounce back to d before the count completes restarts the count from 0.
- Press event = d rising (0->1). Release events generate nothing.
- Pending/arbiter:
  - pending[2:0] = {left, right, center}. A press event sets its pending bit on the same edge that d rises.
  - Each cycle, if any pending bit is set, the highest-priority bit (left > right > center) is cleared and its pulse output is registered high for exactly one cycle.
  - At most one of left/right/center is high in any cycle (one-hot or zero).
  - Simultaneous events on different channels are serialized in priority order on consecutive cycles; none is lost.
  - A new event on a channel whose pending bit is already set merges: one pulse only.
  - A set and a clear of the same bit on the same edge: the set wins.
- Latency: raw press stable from edge 0 -> sync2 at edge 1 -> d rises at edge DEBOUNCE_CYCLES+1 -> pulse high for the cycle after edge DEBOUNCE_CYCLES+2.
- lvl outputs equal d directly, registered, with no arbitration.
- Holding a button produces exactly one pulse; there is no auto-repeat.

Decomposition:
- Shared package: pulse-priority index constants (LEFT=2, RIGHT=1, CENTER=0) and the default debounce constant.
- One natural sub-module, debounce_channel (synchronizer + counter + level + rise detect), instantiated three times.
- Arbitration and pending logic live in the top of button_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset: hold rst, raw all 1 -> every output 0; release rst with btn_left_raw=0 already held -> no pulse; release, then press again -> one left pulse.
- Clean press: btn_right_raw 1->0 before edge 0 and held -> right_lvl=1 after edge 5; right=1 only in the cycle after edge 6; no further pulse while held.
- Bounce: btn_center_raw toggles 0,1,0,1 on consecutive edges, then 0 stable -> exactly one center pulse, 6 edges after the final stable 0; none earlier.
- Simultaneous: all three pressed on the same edge -> left, right, center each high for one cycle on three consecutive cycles, in that order; never two at once.
- Reset mid-debounce: press left, assert rst at edge 3, release rst with left still held -> no left pulse until release and re-press.
- Release: button released after a pulse -> lvl falls 6 edges later; no pulse on release.
